// File: rtl/ghost_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ghost_motion_ctrl
// Description : Per-frame motion controller for one ghost sprite. Moves the
//               ghost along one axis at a time in fixed-point steps, steering
//               toward a target (CHASE) or wandering at half speed (FRIGHT).
// Revision    : 1.0 - initial release
// ============================================================================
module ghost_motion_ctrl #(
  parameter int INITIAL_X   = 400,
  parameter int INITIAL_Y   = 330,
  parameter int SPEED       = 128,
  parameter int FRAC_BITS   = 6,
  parameter int OBJ_W       = 32,
  parameter int OBJ_H       = 32,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int MARGIN      = 2,
  parameter int TURN_PERIOD = 1,
  parameter int FRIGHT_SECS = 5
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               oneSecPulse,
  input  logic               playGame,
  input  logic               collision,
  input  logic        [1:0]  collisionSide,
  input  logic        [1:0]  randomDir,
  input  logic               frightenReq,
  input  logic signed [10:0] targetX,
  input  logic signed [10:0] targetY,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic        [1:0]  dir,
  output logic               frightened
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MOVE       = 3'd1,
    S_WAIT_EOF   = 3'd2,
    S_POS_CHANGE = 3'd3,
    S_POS_LIMITS = 3'd4
  } state_t;

  localparam logic signed [31:0] c_INIT_X       = INITIAL_X <<< FRAC_BITS;
  localparam logic signed [31:0] c_INIT_Y       = INITIAL_Y <<< FRAC_BITS;
  localparam logic signed [31:0] c_X_MIN        = MARGIN <<< FRAC_BITS;
  localparam logic signed [31:0] c_Y_MIN        = MARGIN <<< FRAC_BITS;
  localparam logic signed [31:0] c_X_MAX        = (SCREEN_W - 1 - MARGIN - OBJ_W) <<< FRAC_BITS;
  localparam logic signed [31:0] c_Y_MAX        = (SCREEN_H - 1 - MARGIN - OBJ_H) <<< FRAC_BITS;
  localparam logic signed [31:0] c_SPEED_CHASE  = SPEED;
  localparam logic signed [31:0] c_SPEED_FRIGHT = SPEED >>> 1;
  localparam logic        [31:0] c_TURN_LAST    = TURN_PERIOD - 1;
  localparam logic        [31:0] c_FRIGHT_LOAD  = FRIGHT_SECS;

  state_t             r_state;
  logic signed [31:0] r_pos_x;
  logic signed [31:0] r_pos_y;
  logic        [1:0]  r_dir;
  logic               r_fright;
  logic        [31:0] r_turn_cnt;
  logic        [31:0] r_fright_cnt;
  logic               r_pending;

  logic signed [11:0] w_dx;
  logic signed [11:0] w_dy;
  logic        [11:0] w_abs_dx;
  logic        [11:0] w_abs_dy;
  logic        [1:0]  w_chase_dir;
  logic        [1:0]  w_turn_dir;
  logic        [1:0]  w_side_dir;
  logic        [1:0]  w_dir_fsm;
  logic signed [31:0] w_speed;
  logic               w_x_lo, w_x_hi, w_y_lo, w_y_hi;
  logic               w_fright_flip;

  assign topLeftX   = 11'(r_pos_x >>> FRAC_BITS);
  assign topLeftY   = 11'(r_pos_y >>> FRAC_BITS);
  assign dir        = r_dir;
  assign frightened = r_fright;

  // Steering toward the target: the dominant-distance axis wins, ties go to X.
  assign w_dx        = {targetX[10], targetX} - {topLeftX[10], topLeftX};
  assign w_dy        = {targetY[10], targetY} - {topLeftY[10], topLeftY};
  assign w_abs_dx    = w_dx[11] ? 12'(-w_dx) : 12'(w_dx);
  assign w_abs_dy    = w_dy[11] ? 12'(-w_dy) : 12'(w_dy);
  assign w_chase_dir = (w_abs_dx >= w_abs_dy) ? (w_dx[11] ? 2'd2 : 2'd0)
                                              : (w_dy[11] ? 2'd3 : 2'd1);
  assign w_turn_dir  = r_fright ? randomDir : w_chase_dir;

  // Wall side encoding 00/01/10/11 maps to direction 0/2/1/3 by swapping bits.
  assign w_side_dir    = {collisionSide[0], collisionSide[1]};
  assign w_speed       = r_fright ? c_SPEED_FRIGHT : c_SPEED_CHASE;
  assign w_x_lo        = (r_pos_x < c_X_MIN);
  assign w_x_hi        = (r_pos_x > c_X_MAX);
  assign w_y_lo        = (r_pos_y < c_Y_MIN);
  assign w_y_hi        = (r_pos_y > c_Y_MAX);
  assign w_fright_flip = frightenReq && (r_state != S_IDLE) && !r_fright;

  // Direction chosen by the FSM this cycle (before any fright-entry reversal).
  always_comb begin
    w_dir_fsm = r_dir;
    case (r_state)
      S_MOVE: begin
        if (collision) begin
          if (r_dir == w_side_dir) w_dir_fsm = r_dir ^ 2'd2;
        end else if (r_pending) begin
          w_dir_fsm = w_turn_dir;
        end
      end
      S_POS_LIMITS: begin
        if ((w_x_lo && r_dir == 2'd2) || (w_x_hi && r_dir == 2'd0) ||
            (w_y_lo && r_dir == 2'd3) || (w_y_hi && r_dir == 2'd1))
          w_dir_fsm = r_dir ^ 2'd2;
      end
      default: ;
    endcase
  end

  // Main motion FSM: state, position and direction.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_pos_x <= c_INIT_X;
      r_pos_y <= c_INIT_Y;
      r_dir   <= 2'd2;
    end else if (r_state == S_IDLE) begin
      r_pos_x <= c_INIT_X;
      r_pos_y <= c_INIT_Y;
      r_dir   <= 2'd2;
      if (playGame) r_state <= S_MOVE;
    end else if (!playGame) begin
      r_state <= S_IDLE;
    end else begin
      r_dir <= w_dir_fsm ^ {w_fright_flip, 1'b0};
      case (r_state)
        S_MOVE: begin
          if (startOfFrame)   r_state <= S_POS_CHANGE;
          else if (collision) r_state <= S_WAIT_EOF;
        end
        S_WAIT_EOF: begin
          if (startOfFrame) r_state <= S_POS_CHANGE;
        end
        S_POS_CHANGE: begin
          case (r_dir)
            2'd0: r_pos_x <= r_pos_x + w_speed;
            2'd1: r_pos_y <= r_pos_y + w_speed;
            2'd2: r_pos_x <= r_pos_x - w_speed;
            default: r_pos_y <= r_pos_y - w_speed;
          endcase
          r_state <= S_POS_LIMITS;
        end
        S_POS_LIMITS: begin
          if (w_x_lo)      r_pos_x <= c_X_MIN;
          else if (w_x_hi) r_pos_x <= c_X_MAX;
          if (w_y_lo)      r_pos_y <= c_Y_MIN;
          else if (w_y_hi) r_pos_y <= c_Y_MAX;
          r_state <= S_MOVE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Steering-decision timer; a new pulse beats a same-cycle consumption.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_turn_cnt <= '0;
      r_pending  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_turn_cnt <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (r_state == S_MOVE && (collision || r_pending)) r_pending <= 1'b0;
      if (oneSecPulse) begin
        if (r_turn_cnt >= c_TURN_LAST) begin
          r_turn_cnt <= '0;
          r_pending  <= 1'b1;
        end else begin
          r_turn_cnt <= r_turn_cnt + 32'd1;
        end
      end
    end
  end

  // Fright timer; a request reloads it even when a second tick lands with it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_fright_cnt <= '0;
      r_fright     <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_fright_cnt <= '0;
      r_fright     <= 1'b0;
    end else if (frightenReq) begin
      r_fright_cnt <= c_FRIGHT_LOAD;
      r_fright     <= 1'b1;
    end else if (oneSecPulse && r_fright) begin
      r_fright_cnt <= r_fright_cnt - 32'd1;
      if (r_fright_cnt <= 32'd1) r_fright <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ghost_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ghost_motion_ctrl
// Description : Directed table-driven bench for ghost_motion_ctrl with
//               hand-written sequences for clamp timing, turn discard and
//               playGame drop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ghost_motion_ctrl;

  logic              clk = 1'b0;
  logic              resetN = 1'b0;
  logic              startOfFrame = 1'b0;
  logic              oneSecPulse = 1'b0;
  logic              playGame = 1'b0;
  logic              collision = 1'b0;
  logic        [1:0] collisionSide = 2'd0;
  logic        [1:0] randomDir = 2'd0;
  logic              frightenReq = 1'b0;
  logic signed [10:0] targetX = 11'sd100;
  logic signed [10:0] targetY = 11'sd330;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic        [1:0] dir;
  logic              frightened;

  int total = 0;
  int bad   = 0;

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  ghost_motion_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .oneSecPulse  (oneSecPulse),
    .playGame     (playGame),
    .collision    (collision),
    .collisionSide(collisionSide),
    .randomDir    (randomDir),
    .frightenReq  (frightenReq),
    .targetX      (targetX),
    .targetY      (targetY),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .dir          (dir),
    .frightened   (frightened)
  );

  typedef struct {
    logic       sof;
    logic       sec;
    logic       col;
    logic [1:0] side;
    logic       freq;
    int         tx;
    int         ty;
    int         ex;
    int         ey;
    int         edir;
    int         efr;
  } vec_t;

  vec_t vecs[29];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic setv(input int i, input int sof, input int sec, input int col,
                      input int side, input int freq, input int tx, input int ty,
                      input int ex, input int ey, input int edir, input int efr);
    vecs[i].sof  = sof[0];
    vecs[i].sec  = sec[0];
    vecs[i].col  = col[0];
    vecs[i].side = side[1:0];
    vecs[i].freq = freq[0];
    vecs[i].tx   = tx;
    vecs[i].ty   = ty;
    vecs[i].ex   = ex;
    vecs[i].ey   = ey;
    vecs[i].edir = edir;
    vecs[i].efr  = efr;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // chase left toward (100,330): 2 px per frame
    for (int i = 0; i < 10; i++) setv(i, 1, 0, 0, 0, 0, 100, 330, 398 - 2 * i, 330, 2, 0);
    setv(10, 0, 0, 1, 0, 0, 100, 330, 380, 330, 2, 0); // side right while left: ignored
    setv(11, 1, 0, 0, 0, 0, 100, 330, 378, 330, 2, 0);
    setv(12, 0, 0, 1, 1, 0, 100, 330, 378, 330, 0, 0); // side left: reverse
    setv(13, 1, 0, 0, 0, 0, 100, 330, 380, 330, 0, 0);
    setv(14, 1, 0, 1, 1, 0, 100, 330, 382, 330, 0, 0); // non-matching + step
    setv(15, 1, 0, 1, 0, 0, 100, 330, 380, 330, 2, 0); // reverse + step same frame
    setv(16, 0, 0, 0, 0, 1, 100, 330, 380, 330, 0, 1); // enter fright, reverse
    setv(17, 1, 0, 0, 0, 0, 100, 330, 381, 330, 0, 1); // half speed
    setv(18, 1, 0, 0, 0, 0, 100, 330, 382, 330, 0, 1);
    setv(19, 0, 1, 0, 0, 0, 100, 330, 382, 330, 0, 1); // pulse 1, random dir 0
    setv(20, 0, 1, 0, 0, 0, 100, 330, 382, 330, 0, 1); // pulse 2
    setv(21, 0, 1, 0, 0, 1, 100, 330, 382, 330, 0, 1); // pulse 3 + retrigger, no reversal
    for (int i = 22; i < 26; i++) setv(i, 0, 1, 0, 0, 0, 100, 330, 382, 330, 0, 1);
    setv(26, 0, 1, 0, 0, 0, 100, 330, 382, 330, 2, 0); // pulse 8: fright ends, chase turn left
    setv(27, 1, 0, 0, 0, 0, 100, 330, 380, 330, 2, 0); // back to 2 px
    setv(28, 0, 1, 0, 0, 0, 600, 100, 380, 330, 3, 0); // |dy|>|dx|, dy<0: up

    randomDir = 2'd0;
    #12;
    check("reset_x", topLeftX, 400);
    check("reset_y", topLeftY, 330);
    check("reset_dir", dir, 2);
    check("reset_fr", frightened, 0);
    resetN   = 1'b1;
    playGame = 1'b1;
    tick();

    for (int i = 0; i < 29; i++) begin
      targetX       = 11'(vecs[i].tx);
      targetY       = 11'(vecs[i].ty);
      startOfFrame  = vecs[i].sof;
      oneSecPulse   = vecs[i].sec;
      collision     = vecs[i].col;
      collisionSide = vecs[i].side;
      frightenReq   = vecs[i].freq;
      tick();
      startOfFrame = 1'b0;
      oneSecPulse  = 1'b0;
      collision    = 1'b0;
      frightenReq  = 1'b0;
      tick();
      tick();
      tick();
      check($sformatf("v%0d_x", i), topLeftX, vecs[i].ex);
      check($sformatf("v%0d_y", i), topLeftY, vecs[i].ey);
      check($sformatf("v%0d_dir", i), dir, vecs[i].edir);
      check($sformatf("v%0d_fr", i), frightened, vecs[i].efr);
    end

    // Climb to the top edge: 164 frames reach exactly y=2 with no bounce.
    for (int k = 0; k < 164; k++) frame();
    check("top_y", topLeftY, 2);
    check("top_x", topLeftX, 380);
    check("top_dir", dir, 3);

    // Overshoot frame: raw step visible one cycle before the clamp.
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("lat_pc_y", topLeftY, 2);
    tick();
    check("lat_step_y", topLeftY, 0);
    tick();
    check("lat_clamp_y", topLeftY, 2);
    check("lat_clamp_dir", dir, 1);
    tick();
    frame();
    check("down_y", topLeftY, 4);
    check("down_dir", dir, 1);

    // Pending turn and matching collision in the same MOVE cycle.
    oneSecPulse = 1'b1;
    tick();
    oneSecPulse   = 1'b0;
    collision     = 1'b1;
    collisionSide = 2'b10;
    tick();
    collision = 1'b0;
    tick();
    tick();
    check("colturn_dir", dir, 3);
    frame();
    check("colturn_y", topLeftY, 2);
    check("colturn_dir2", dir, 3);
    oneSecPulse = 1'b1;
    tick();
    oneSecPulse = 1'b0;
    tick();
    tick();
    check("nextturn_dir", dir, 0);
    frame();
    check("nextturn_x", topLeftX, 382);

    // Enter fright, then drop playGame.
    frightenReq = 1'b1;
    tick();
    frightenReq = 1'b0;
    tick();
    check("pre_drop_fr", frightened, 1);
    check("pre_drop_dir", dir, 2);
    playGame = 1'b0;
    tick();
    check("drop_p1_x", topLeftX, 382);
    tick();
    check("drop_p2_x", topLeftX, 400);
    check("drop_p2_y", topLeftY, 330);
    check("drop_p2_dir", dir, 2);
    check("drop_p2_fr", frightened, 0);
    frame();
    check("idle_sof_x", topLeftX, 400);
    playGame = 1'b1;
    tick();
    frame();
    check("restart_x", topLeftX, 398);
    check("restart_fr", frightened, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ghost_motion_ctrl.md
# ghost_motion_ctrl

Parametrised per-frame motion controller for one ghost sprite; it replaces the fixed random-bounce mover in the VGA object layer. It moves the ghost along one axis at a time in fixed-point steps and supports two modes. In CHASE the ghost steers toward a target position; in FRIGHT it moves at half speed in random directions for a timed interval. It outputs the sprite top-left corner to the drawing/collision logic.

## Interface
Parameters:
- INITIAL_X, 400: start X, pixels
- INITIAL_Y, 330: start Y, pixels
- SPEED, 128: chase speed, fixed-point units per frame (2 px/frame)
- FRAC_BITS, 6: fixed-point fraction bits (multiplier 2^FRAC_BITS)
- OBJ_W / OBJ_H, 32 / 32: sprite size, pixels
- SCREEN_W / SCREEN_H, 640 / 480: frame size, pixels
- MARGIN, 2: safety margin, pixels
- TURN_PERIOD, 1: oneSecPulse count between steering decisions (≥1)
- FRIGHT_SECS, 5: fright duration in oneSecPulse counts

Ports:
- clk, in, 1: clock
- resetN, in, 1: reset, asynchronous, active-low
- startOfFrame, in, 1: one-cycle pulse per frame
- oneSecPulse, in, 1: one-cycle pulse per second
- playGame, in, 1: level-enable; low forces IDLE
- collision, in, 1: ghost hit a wall this cycle
- collisionSide, in, 2: hit side; 00 right, 01 left, 10 down, 11 up
- randomDir, in, 2: LFSR direction for FRIGHT
- frightenReq, in, 1: pulse that enters or retriggers FRIGHT
- targetX / targetY, in, 11 signed: chase target top-left, pixels
- topLeftX / topLeftY, out, 11 signed: sprite position, pixels
- dir, out, 2: current direction; 0 right, 1 down, 2 left, 3 up
- frightened, out, 1: FRIGHT mode active

## Operation
- Position is held in 32-bit signed fixed point. topLeftX/Y = position >>> FRAC_BITS (arithmetic shift).
- Speed magnitude is SPEED in CHASE and SPEED>>1 in FRIGHT. Motion is along dir only; the other axis does not change.
- The FSM has five states: IDLE, MOVE, WAIT_EOF, POS_CHANGE, POS_LIMITS.
- IDLE: load position (INITIAL_X, INITIAL_Y)<<FRAC_BITS, set dir=2, clear mode and counters. Go to MOVE when playGame=1.
- MOVE, in priority order:
  - collision: reverse dir (XOR 2) only if dir points at collisionSide. Side 00 matches dir 0, 01 matches 2, 10 matches 1, 11 matches 3. Discard any pending turn and go to WAIT_EOF.
  - pending turn:
    - CHASE: dx=targetX−topLeftX, dy=targetY−topLeftY. If |dx|≥|dy|, dir = dx≥0 ? 0 : 2; otherwise dir = dy≥0 ? 1 : 3.
    - FRIGHT: dir=randomDir.
    - Clear the pending flag.
  - startOfFrame: go to POS_CHANGE. This also applies in the collision cycle, overriding WAIT_EOF.
- WAIT_EOF: on startOfFrame, go to POS_CHANGE.
- POS_CHANGE: add ±speed to the active axis and go to POS_LIMITS.
- POS_LIMITS:
  - Bounds: X in [MARGIN, SCREEN_W−1−MARGIN−OBJ_W]<<FRAC_BITS; Y in [MARGIN, SCREEN_H−1−MARGIN−OBJ_H]<<FRAC_BITS.
  - On violation, clamp to the bound and reverse dir if it points outward.
  - Go to MOVE.
- Turn counter:
  - Counts oneSecPulse in any non-IDLE state.
  - At TURN_PERIOD it wraps to 0 and sets the pending flag.
  - The flag is sticky until consumed in MOVE.
- Fright counter:
  - frightenReq (non-IDLE) loads FRIGHT_SECS and sets frightened=1.
  - If the ghost was not already frightened, dir also reverses.
  - Each oneSecPulse decrements the counter. Reaching 0 clears frightened.
  - frightenReq and oneSecPulse in the same cycle: load wins.
- playGame=0 in any state: go to IDLE next cycle.

## Timing
- Reset values: topLeftX=INITIAL_X, topLeftY=INITIAL_Y, dir=2, frightened=0, FSM=IDLE, counters 0, pending=0.
- All state is registered; outputs are combinational from registers.
- startOfFrame seen in MOVE at cycle T: POS_CHANGE at T+1, new position visible at T+2, clamped value at T+3, back in MOVE at T+3.
- startOfFrame outside MOVE/WAIT_EOF is dropped (at most one step per frame).
- Collision and startOfFrame in the same MOVE cycle: reversal and the step both happen in that frame.
- frightened updates one cycle after the triggering pulse. The speed change applies from the next POS_CHANGE.
- playGame drop: FSM is IDLE at +1 and the outputs show the initial position at +2.

## Test plan
- Reset, then playGame=1 with target (100,330) and 10 startOfFrame pulses: topLeftX 400→380, topLeftY=330, dir=2.
- Moving left, collision=1 with collisionSide=01: dir=0. The next frame gives X+2. With collisionSide=00 instead, dir is unchanged.
- frightenReq while moving left: dir=0 and frightened=1. Steps are 1 px/frame. After 5 oneSecPulse frightened=0; a second frightenReq at pulse 3 extends it to pulse 8.
- Target (600,100) from (400,330) with one oneSecPulse: |dy|>|dx| gives dir=3. Y decreases 2 px/frame until it clamps at 2, then dir=1.
- Same-cycle collision (matching side) and pending turn: the reversal is applied, the turn is discarded, and dir holds until the next oneSecPulse.
- playGame deasserted mid-move after X=350: outputs (400,330) two cycles later, dir=2, frightened=0.
